// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer: drives a single-bit ALU slice LSB first, one bit per clock,
// feeding the carry back between bits and returning the assembled word over valid/ready.
module alu_serial_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic             req_sub,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_op0,
    output logic             alu_op1,
    output logic             alu_cin,
    output logic             alu_binv,
    input  logic             alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_error
);

    localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [1:0]       OP_ADD   = 2'b10;
    localparam logic [1:0]       OP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            error_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            error_q  <= error_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sub_d      = sub_q;
        result_d   = result_q;
        carry_d    = carry_q;
        error_d    = error_q;
        idx_d      = idx_q;
        req_ready  = 1'b0;
        alu_a      = 1'b0;
        alu_b      = 1'b0;
        alu_op0    = 1'b0;
        alu_op1    = 1'b0;
        alu_cin    = 1'b0;
        alu_binv   = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        rsp_carry  = 1'b0;
        rsp_zero   = 1'b0;
        rsp_error  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    op_d     = req_op;
                    sub_d    = req_sub;
                    result_d = '0;
                    idx_d    = '0;
                    carry_d  = (req_op == OP_ADD) && req_sub;
                    error_d  = (req_op == OP_ILL);
                    state_d  = (req_op == OP_ILL) ? DONE : RUN;
                end
            end
            RUN: begin
                alu_a    = a_q[idx_q];
                alu_b    = b_q[idx_q];
                alu_op0  = op_q[0];
                alu_op1  = op_q[1];
                alu_binv = sub_q;
                alu_cin  = (op_q == OP_ADD) ? carry_q : 1'b0;
                result_d[idx_q] = alu_y;
                if (op_q == OP_ADD) begin
                    carry_d = alu_cout;
                end
                // idx wraps on the last bit, but RUN is left on that same edge
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_result = result_q;
                rsp_carry  = (op_q == OP_ADD) ? carry_q : 1'b0;
                rsp_zero   = !error_q && (result_q == '0);
                rsp_error  = error_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural single-bit ALU slice
// closing the loop on the alu_* outputs.
module tb_alu_serial_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_op;
    logic       req_sub;
    logic       alu_a, alu_b, alu_op0, alu_op1, alu_cin, alu_binv;
    logic       alu_y, alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_zero, rsp_error;

    int checks = 0;
    int errors = 0;

    alu_serial_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_sub    (req_sub),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op0    (alu_op0),
        .alu_op1    (alu_op1),
        .alu_cin    (alu_cin),
        .alu_binv   (alu_binv),
        .alu_y      (alu_y),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_error  (rsp_error)
    );

    // Single-bit ALU slice: AND / OR / full-add on (A, B^Binv)
    logic bb;
    always_comb begin
        bb = alu_b ^ alu_binv;
        case ({alu_op1, alu_op0})
            2'b00:   alu_y = alu_a & bb;
            2'b01:   alu_y = alu_a | bb;
            2'b10:   alu_y = alu_a ^ bb ^ alu_cin;
            default: alu_y = 1'b0;
        endcase
        alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_flags"}, 32'({rsp_carry, rsp_zero, rsp_error}), 32'd0);
        check({tag, "_alu"}, 32'({alu_a, alu_b, alu_op0, alu_op1, alu_cin, alu_binv}), 32'd0);
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic sub);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_sub   = sub;
        req_valid = 1'b1;
        #1;
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_alu_quiet", 32'({alu_a, alu_b, alu_op0, alu_op1, alu_cin, alu_binv}), 32'd0);
        tick;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
        req_op    = ~op;
        req_sub   = ~sub;
    endtask

    task automatic run_bits(input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] op, input logic sub);
        logic c;
        logic bi;
        c = (op == 2'b10) && sub;
        for (int i = 0; i < 8; i++) begin
            check("run_req_ready", 32'(req_ready), 32'd0);
            check("run_rsp_valid", 32'(rsp_valid), 32'd0);
            check("run_alu_a", 32'(alu_a), 32'(a[i]));
            check("run_alu_b", 32'(alu_b), 32'(b[i]));
            check("run_alu_ctl", 32'({alu_op1, alu_op0, alu_binv}), 32'({op, sub}));
            check("run_alu_cin", 32'(alu_cin), (op == 2'b10) ? 32'(c) : 32'd0);
            bi = b[i] ^ sub;
            if (op == 2'b10) c = (a[i] & bi) | (a[i] & c) | (bi & c);
            tick;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] res, input logic carry,
                             input logic zero, input logic err);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'(res));
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 32'(carry));
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(zero));
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'(err));
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_sub   = 1'b0;
        rsp_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        tick;
        check_reset_outputs("idle");

        // ADD 0x35 + 0x4A; rsp_valid exactly 8 edges after accept
        start(8'h35, 8'h4A, 2'b10, 1'b0);
        run_bits(8'h35, 8'h4A, 2'b10, 1'b0);
        check_rsp("add", 8'h7F, 1'b0, 1'b0, 1'b0);
        handshake;

        start(8'h10, 8'h10, 2'b10, 1'b1);
        run_bits(8'h10, 8'h10, 2'b10, 1'b1);
        check_rsp("sub_eq", 8'h00, 1'b1, 1'b1, 1'b0);
        handshake;

        start(8'h05, 8'h07, 2'b10, 1'b1);
        run_bits(8'h05, 8'h07, 2'b10, 1'b1);
        check_rsp("sub_neg", 8'hFE, 1'b0, 1'b0, 1'b0);
        handshake;

        start(8'hF0, 8'h3C, 2'b00, 1'b0);
        run_bits(8'hF0, 8'h3C, 2'b00, 1'b0);
        check_rsp("and", 8'h30, 1'b0, 1'b0, 1'b0);
        handshake;

        start(8'hF0, 8'h0C, 2'b01, 1'b0);
        run_bits(8'hF0, 8'h0C, 2'b01, 1'b0);
        check_rsp("or", 8'hFC, 1'b0, 1'b0, 1'b0);
        handshake;

        // Illegal op: response on the cycle after accept, slice never driven
        start(8'hAA, 8'h55, 2'b11, 1'b1);
        check("ill_alu_quiet", 32'({alu_a, alu_b, alu_op0, alu_op1, alu_cin, alu_binv}), 32'd0);
        check_rsp("ill", 8'h00, 1'b0, 1'b0, 1'b1);
        handshake;

        // Backpressure with a pending request that must wait for the handshake
        start(8'hFF, 8'h01, 2'b10, 1'b0);
        run_bits(8'hFF, 8'h01, 2'b10, 1'b0);
        check_rsp("bp0", 8'h00, 1'b1, 1'b1, 1'b0);
        req_a     = 8'h80;
        req_b     = 8'h01;
        req_op    = 2'b10;
        req_sub   = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            check_rsp("bp_hold", 8'h00, 1'b1, 1'b1, 1'b0);
        end
        handshake;
        tick;
        check("b2b_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        run_bits(8'h80, 8'h01, 2'b10, 1'b1);
        check_rsp("b2b", 8'h7F, 1'b1, 1'b0, 1'b0);
        handshake;

        // Asynchronous reset after three bits of a run
        start(8'hC3, 8'h3C, 2'b10, 1'b0);
        tick;
        tick;
        tick;
        check("pre_reset_alu_a", 32'(alu_a), 32'd0);
        check("pre_reset_alu_b", 32'(alu_b), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick;
        check_reset_outputs("reset_held");
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        start(8'h35, 8'h4A, 2'b10, 1'b0);
        run_bits(8'h35, 8'h4A, 2'b10, 1'b0);
        check_rsp("after_reset", 8'h7F, 1'b0, 1'b0, 1'b0);
        handshake;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
